// File: rtl/dfr_argmax_pkg.sv
// dfr_argmax_pkg: shared types for the argmax scanner (state encoding, result record).
package dfr_argmax_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  localparam int READ_LATENCY = 1;
  localparam int RES_W = 64;
  typedef struct packed {
    logic [RES_W-1:0] index;
    logic [RES_W-1:0] value;
  } result_t;
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: greater-than unit and starting floor; DFR_ARGMAX_SIGNED_EN selects signed compare.
module argmax_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic [W-1:0] floor_val
);
`ifdef DFR_ARGMAX_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
  assign floor_val = {1'b1, {(W-1){1'b0}}};
`else
  assign gt = a > b;
  assign floor_val = '0;
`endif
endmodule

// File: rtl/dfr_argmax.sv
// dfr_argmax: scans a score RAM (1-cycle read) and publishes index/value of the largest entry.
// Build option DFR_ARGMAX_SIGNED_EN switches to signed scores (handled inside argmax_cmp).
module dfr_argmax
  import dfr_argmax_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_entries,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] max_index,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic                  busy,
  output logic                  done
);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] n, cidx, last;
  logic [DATA_WIDTH-1:0] floor_val;
  logic dv, first, gt, take;
  result_t best, cand;

  argmax_cmp #(.W(DATA_WIDTH)) u_cmp (
    .a(rd_data), .b(best.value[DATA_WIDTH-1:0]), .gt(gt), .floor_val(floor_val)
  );

  assign last = n - ADDR_WIDTH'(1);
  assign take = dv && (first || gt);
  assign cand = take ? result_t'{index: RES_W'(cidx), value: RES_W'(rd_data)} : best;

  always_comb begin
    next = state == IDLE  ? (start ? (num_entries == '0 ? DONE : SCAN) : IDLE)
         : state == SCAN  ? (rd_addr == last ? FLUSH : SCAN)
         : state == FLUSH ? DONE : IDLE;
  end

  // dv marks cycles where rd_data belongs to an issued address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      rd_addr   <= '0;
      cidx      <= '0;
      dv        <= 1'b0;
      first     <= 1'b0;
      best      <= '0;
      max_index <= '0;
      max_value <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= next;
      busy  <= next == SCAN || next == FLUSH;
      done  <= next == DONE;
      dv    <= state == SCAN;
      if (state == IDLE && start) begin
        n       <= num_entries;
        rd_addr <= '0;
        cidx    <= '0;
        first   <= 1'b1;
        best    <= result_t'{index: '0, value: RES_W'(floor_val)};
      end else if (state == SCAN && rd_addr != last) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end else if (state == DONE) begin
        rd_addr <= '0;
      end
      if (dv) begin
        best  <= cand;
        cidx  <= cidx + ADDR_WIDTH'(1);
        first <= 1'b0;
      end
      if (next == DONE) begin
        max_index <= state == FLUSH ? cand.index[ADDR_WIDTH-1:0] : '0;
        max_value <= state == FLUSH ? cand.value[DATA_WIDTH-1:0] : '0;
      end
    end
  end
endmodule

// File: tb/tb_dfr_argmax.sv
// tb_dfr_argmax: directed checks of dfr_argmax against a 1-cycle-latency RAM model.
module tb_dfr_argmax;
  logic        clk = 0, rst = 1, start = 0;
  logic [31:0] num_entries = 0, rd_data, rd_addr, max_index, max_value;
  logic        busy, done;
  logic [31:0] mem [0:15];
  int n_tests = 0, n_fail = 0;

  dfr_argmax #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_entries(num_entries), .rd_data(rd_data),
    .rd_addr(rd_addr), .max_index(max_index), .max_value(max_value), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scan(input string tag, input logic [31:0] n, input int exp_lat,
                      input logic [31:0] ei, ev, hi, hv, input bit repulse);
    int lat, extra;
    bit bad_busy, bad_hold;
    bad_busy = 0; bad_hold = 0; extra = 0;
    @(negedge clk); start = 1; num_entries = n;
    @(posedge clk); #1; start = 0; lat = 1;
    while (!done && lat < 64) begin
      if (!busy) bad_busy = 1;
      if (max_index !== hi || max_value !== hv) bad_hold = 1;
      if (repulse && lat == 3) begin start = 1; num_entries = 2; end else start = 0;
      @(posedge clk); #1; lat++;
    end
    start = 0;
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy_during"}, 64'(bad_busy), 0);
    chk({tag, ".hold"}, 64'(bad_hold), 0);
    chk({tag, ".busy_at_done"}, 64'(busy), 0);
    chk({tag, ".index"}, 64'(max_index), 64'(ei));
    chk({tag, ".value"}, 64'(max_value), 64'(ev));
    if (n == 0) chk({tag, ".rd_addr_n0"}, 64'(rd_addr), 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(done), 0);
    chk({tag, ".rd_addr_idle"}, 64'(rd_addr), 0);
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done) extra++; end
    chk({tag, ".no_extra_done"}, 64'(extra), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    #2;
    chk("reset.rd_addr", 64'(rd_addr), 0);
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.max_index", 64'(max_index), 0);
    chk("reset.max_value", 64'(max_value), 0);
    @(negedge clk); rst = 0;

    mem[0] = 3; mem[1] = 9; mem[2] = 4; mem[3] = 9; mem[4] = 1;
    scan("tie5", 5, 7, 1, 9, 0, 0, 0);
    scan("empty", 0, 1, 0, 0, 1, 9, 0);
    mem[0] = 32'hDEADBEEF;
    scan("single", 1, 3, 0, 32'hDEADBEEF, 0, 0, 0);

    mem[0] = 5; mem[1] = 32'hFFFFFFFE; mem[2] = 7;
`ifdef DFR_ARGMAX_SIGNED_EN
    scan("sign3", 3, 5, 2, 7, 0, 32'hDEADBEEF, 0);
    mem[0] = 2; mem[1] = 7; mem[2] = 7; mem[3] = 1; mem[4] = 8; mem[5] = 3; mem[6] = 8; mem[7] = 0;
    scan("repulse8", 8, 10, 4, 8, 2, 7, 1);
`else
    scan("sign3", 3, 5, 1, 32'hFFFFFFFE, 0, 32'hDEADBEEF, 0);
    mem[0] = 2; mem[1] = 7; mem[2] = 7; mem[3] = 1; mem[4] = 8; mem[5] = 3; mem[6] = 8; mem[7] = 0;
    scan("repulse8", 8, 10, 4, 8, 1, 32'hFFFFFFFE, 1);
`endif

    @(negedge clk); start = 1; num_entries = 6;
    @(posedge clk); #1; start = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1; #1;
    chk("midrst.rd_addr", 64'(rd_addr), 0);
    chk("midrst.busy", 64'(busy), 0);
    chk("midrst.done", 64'(done), 0);
    chk("midrst.max_index", 64'(max_index), 0);
    chk("midrst.max_value", 64'(max_value), 0);
    @(negedge clk); rst = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done) seen++; end
      chk("midrst.no_done", 64'(seen), 0);
    end
    for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
    scan("after_rst", 6, 8, 5, 6, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
